// File: rtl/classifier_helpers_pkg.sv
// Shared types and helpers for the classifier helper blocks.
package classifier_helpers_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } bin_seq_state_t;

  // Right-shift that turns i*fs into the bin centre frequency for an N-point FFT.
  function automatic int unsigned bin_freq_shift(input int unsigned n_samples);
    return $clog2(n_samples) + 1;
  endfunction

endpackage

// File: rtl/classifier_helpers_bin_accumulator.sv
// Bin counter plus wide accumulator: produces f_i = (i*fs) >> (log2(N)+1)
// incrementally, one bin per step, with no multiplier.
module classifier_helpers_bin_accumulator
  import classifier_helpers_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 step,
  input  logic [BIT_WIDTH-1:0] fs,
  output logic [((N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1)-1:0] bin_idx,
  output logic [BIT_WIDTH-1:0] f_i,
  output logic                 last
);

  localparam int LOG2N = $clog2(N_SAMPLES);
  localparam int CNT_W = (LOG2N > 0) ? LOG2N : 1;
  localparam int ACC_W = BIT_WIDTH + LOG2N;
  localparam int SHIFT = int'(bin_freq_shift(N_SAMPLES));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  // Next counter/accumulator: clear wins over step; acc tracks i*fs exactly.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = acc_q + ACC_W'(fs);
    end
  end

  // Counter and accumulator registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  // acc <= (N-1)*fs < 2^(ACC_W), so acc >> SHIFT always fits in BIT_WIDTH-1
  // bits; the top bit of f_i is therefore a constant zero.
  assign f_i     = BIT_WIDTH'(acc_q[ACC_W-1:SHIFT]);
  assign bin_idx = cnt_q;
  assign last    = (cnt_q == CNT_W'(N_SAMPLES - 1));

endmodule

// File: rtl/classifier_helpers_bin_mask_sequencer.sv
// Walks the FFT bins one per cycle and builds a pass mask for the band
// [cutoff_lo, cutoff_hi]. Config arrives on a val/rdy request, the finished
// mask leaves on a val/rdy response.
module classifier_helpers_bin_mask_sequencer
  import classifier_helpers_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] sampling_freq,
  input  logic [BIT_WIDTH-1:0] cutoff_lo,
  input  logic [BIT_WIDTH-1:0] cutoff_hi,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [N_SAMPLES-1:0] mask_out
);

  localparam int LOG2N = $clog2(N_SAMPLES);
  localparam int CNT_W = (LOG2N > 0) ? LOG2N : 1;

  if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0)) begin : g_bad_n
    $error("N_SAMPLES must be a power of 2 and at least 2");
  end

  bin_seq_state_t       state_q, state_d;
  logic [BIT_WIDTH-1:0] fs_q, fs_d;
  logic [BIT_WIDTH-1:0] lo_q, lo_d;
  logic [BIT_WIDTH-1:0] hi_q, hi_d;
  logic [N_SAMPLES-1:0] mask_q, mask_d;

  logic                 acc_clear;
  logic                 acc_step;
  logic [CNT_W-1:0]     bin_idx;
  logic [BIT_WIDTH-1:0] bin_freq;
  logic                 bin_last;
  logic                 bin_hit;

  classifier_helpers_bin_accumulator #(
    .BIT_WIDTH (BIT_WIDTH),
    .N_SAMPLES (N_SAMPLES)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   (acc_clear),
    .step    (acc_step),
    .fs      (fs_q),
    .bin_idx (bin_idx),
    .f_i     (bin_freq),
    .last    (bin_last)
  );

  // Inclusive unsigned band test for the bin currently being evaluated.
  always_comb begin
    bin_hit = (bin_freq >= lo_q) && (bin_freq <= hi_q);
  end

  // FSM next state, handshake outputs, config latch and mask update.
  always_comb begin
    state_d   = state_q;
    fs_d      = fs_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    mask_d    = mask_q;
    acc_clear = 1'b0;
    acc_step  = 1'b0;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    case (state_q)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          fs_d      = sampling_freq;
          lo_d      = cutoff_lo;
          hi_d      = cutoff_hi;
          mask_d    = '0;
          acc_clear = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        mask_d[bin_idx] = bin_hit;
        acc_step        = 1'b1;
        if (bin_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and mask: both return to their idle values on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Latched configuration; only meaningful after a request, so not reset.
  always_ff @(posedge clk) begin
    fs_q <= fs_d;
    lo_q <= lo_d;
    hi_q <= hi_d;
  end

  assign mask_out = mask_q;

endmodule

// File: tb/tb_classifier_helpers_bin_mask_sequencer.sv
// Bench for the bin mask sequencer: directed and random requests compared
// against a plain-arithmetic model of the band mask.
module tb_classifier_helpers_bin_mask_sequencer;

  localparam int BW    = 32;
  localparam int N     = 16;
  localparam int SHIFT = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          recv_val;
  logic          recv_rdy;
  logic [BW-1:0] sampling_freq;
  logic [BW-1:0] cutoff_lo;
  logic [BW-1:0] cutoff_hi;
  logic          send_val;
  logic          send_rdy;
  logic [N-1:0]  mask_out;

  int total = 0;
  int bad   = 0;

  classifier_helpers_bin_mask_sequencer #(
    .BIT_WIDTH (BW),
    .N_SAMPLES (N)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .recv_val      (recv_val),
    .recv_rdy      (recv_rdy),
    .sampling_freq (sampling_freq),
    .cutoff_lo     (cutoff_lo),
    .cutoff_hi     (cutoff_hi),
    .send_val      (send_val),
    .send_rdy      (send_rdy),
    .mask_out      (mask_out)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: f_i = floor(i*fs / 2^(log2N+1)), bit set iff lo <= f_i <= hi.
  function automatic logic [N-1:0] model(input logic [BW-1:0] fs,
                                         input logic [BW-1:0] lo,
                                         input logic [BW-1:0] hi);
    logic [N-1:0]    m;
    longint unsigned f;
    m = '0;
    for (int i = 0; i < N; i++) begin
      f = (64'(i) * 64'(fs)) >> SHIFT;
      m[i] = (f >= 64'(lo)) && (f <= 64'(hi));
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for send_val; first call point is one negedge after the
  // handshake edge, so a 17-cycle request->response latency gives n == 17.
  task automatic wait_resp(input string tag);
    int n;
    n = 1;
    while (send_val !== 1'b1 && n < 40) begin
      if (n == 8) chk({tag, "_rdy_calc"}, 32'(recv_rdy), 32'd0);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd17);
  endtask

  // One request with `hold` cycles of backpressure in DONE.
  task automatic run_req(input string tag, input logic [BW-1:0] fs,
                         input logic [BW-1:0] lo, input logic [BW-1:0] hi,
                         input logic [N-1:0] exp_mask, input int hold);
    sampling_freq = fs;
    cutoff_lo     = lo;
    cutoff_hi     = hi;
    recv_val      = 1'b1;
    send_rdy      = 1'b0;
    chk({tag, "_rdy_idle"}, 32'(recv_rdy), 32'd1);
    @(negedge clk);
    recv_val      = 1'b0;
    sampling_freq = $urandom;
    cutoff_lo     = $urandom;
    cutoff_hi     = $urandom;
    wait_resp(tag);
    chk({tag, "_mask"}, 32'(mask_out), 32'(exp_mask));
    for (int k = 0; k < hold; k++) begin
      recv_val      = 1'b1;
      sampling_freq = $urandom;
      @(negedge clk);
      chk({tag, "_hold_val"}, 32'(send_val), 32'd1);
      chk({tag, "_hold_mask"}, 32'(mask_out), 32'(exp_mask));
      chk({tag, "_hold_rdy"}, 32'(recv_rdy), 32'd0);
    end
    recv_val = 1'b0;
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    chk({tag, "_ret_rdy"}, 32'(recv_rdy), 32'd1);
    chk({tag, "_ret_val"}, 32'(send_val), 32'd0);
    chk({tag, "_ret_mask"}, 32'(mask_out), 32'(exp_mask));
  endtask

  initial begin
    logic [BW-1:0] fs, lo, hi;
    logic [BW-1:0] fs_b, lo_b, hi_b;

    reset         = 1'b1;
    recv_val      = 1'b0;
    send_rdy      = 1'b0;
    sampling_freq = '0;
    cutoff_lo     = '0;
    cutoff_hi     = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(recv_rdy), 32'd1);
    chk("rst_val", 32'(send_val), 32'd0);
    chk("rst_mask", 32'(mask_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed band cases.
    run_req("band500", 32'd16000, 32'd1000, 32'd3000, 16'h007C, 5);
    run_req("dc_only", 32'd44100, 32'd0, 32'd0, 16'h0001, 0);
    run_req("bin1", 32'd44100, 32'd1378, 32'd1378, 16'h0002, 2);
    run_req("inverted", 32'd16000, 32'd5000, 32'd2000, 16'h0000, 1);
    run_req("fs0_lo0", 32'd0, 32'd0, 32'd10, 16'hFFFF, 0);
    run_req("fs0_lo1", 32'd0, 32'd1, 32'd10, 16'h0000, 0);

    // Reset in the middle of CALC discards the partial mask.
    sampling_freq = 32'd16000;
    cutoff_lo     = 32'd0;
    cutoff_hi     = 32'd7500;
    recv_val      = 1'b1;
    @(negedge clk);
    recv_val = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_rdy", 32'(recv_rdy), 32'd1);
    chk("midrst_val", 32'(send_val), 32'd0);
    chk("midrst_mask", 32'(mask_out), 32'd0);
    run_req("after_rst", 32'd16000, 32'd0, 32'd7500, 16'hFFFF, 0);

    // Random configurations against the model.
    for (int r = 0; r < 8; r++) begin
      fs = $urandom;
      lo = $urandom_range(0, fs >> 1);
      if (r % 2 == 1) hi = lo + $urandom_range(0, fs >> 2);
      else            hi = $urandom;
      run_req("rand", fs, lo, hi, model(fs, lo, hi), $urandom_range(0, 3));
    end

    // Back-to-back with send_rdy held high and recv_val held high.
    fs   = 32'd16000;
    lo   = 32'd1000;
    hi   = 32'd3000;
    fs_b = $urandom_range(1, 200000);
    lo_b = $urandom_range(0, fs_b >> 2);
    hi_b = lo_b + $urandom_range(0, fs_b >> 2);
    send_rdy      = 1'b1;
    recv_val      = 1'b1;
    sampling_freq = fs;
    cutoff_lo     = lo;
    cutoff_hi     = hi;
    chk("b2b_rdy0", 32'(recv_rdy), 32'd1);
    @(negedge clk);
    sampling_freq = fs_b;
    cutoff_lo     = lo_b;
    cutoff_hi     = hi_b;
    wait_resp("b2b_a");
    chk("b2b_a_mask", 32'(mask_out), 32'(model(fs, lo, hi)));
    @(negedge clk);
    chk("b2b_idle_rdy", 32'(recv_rdy), 32'd1);
    chk("b2b_idle_val", 32'(send_val), 32'd0);
    chk("b2b_idle_mask", 32'(mask_out), 32'(model(fs, lo, hi)));
    @(negedge clk);
    chk("b2b_accept", 32'(recv_rdy), 32'd0);
    recv_val      = 1'b0;
    sampling_freq = $urandom;
    cutoff_lo     = $urandom;
    cutoff_hi     = $urandom;
    wait_resp("b2b_b");
    chk("b2b_b_mask", 32'(mask_out), 32'(model(fs_b, lo_b, hi_b)));
    @(negedge clk);
    chk("b2b_end_val", 32'(send_val), 32'd0);
    chk("b2b_end_rdy", 32'(recv_rdy), 32'd1);
    send_rdy = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
